// File: rtl/prog_loader_pkg.sv
// ---------------------------------------------------------------------------
// prog_loader_pkg
// Shared definitions for the program loader: the loader state encoding and
// the frame geometry constants (header length, bytes per memory word).
// No ports; imported by prog_loader and prog_loader_byte_packer.
// ---------------------------------------------------------------------------
package prog_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam int HDR_BYTES      = 4;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// ---------------------------------------------------------------------------
// prog_loader_byte_packer
// Assembles a byte stream MSB-first into 32-bit words. The completed word is
// held on o_word and announced by a one-cycle o_word_valid pulse in the cycle
// after its last byte was accepted. Also reused by the data-memory dump path.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset
//   i_clear      restart byte alignment at a word boundary
//   i_valid      i_byte is taken this cycle
//   i_byte       stream byte
//   o_word       last completed word (held until the next one completes)
//   o_word_valid one-cycle pulse after a word completes
//   o_byte_cnt   bytes already collected for the word in progress (0..3)
// ---------------------------------------------------------------------------
module prog_loader_byte_packer
    import prog_loader_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clear,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_valid,
    output logic [1:0]  o_byte_cnt
);

    logic [23:0] r_shift;
    logic [31:0] r_word;
    logic        r_word_valid;
    logic [1:0]  r_cnt;
    logic        w_last;

    assign w_last       = i_valid && (r_cnt == 2'(BYTES_PER_WORD - 1));
    assign o_word       = r_word;
    assign o_word_valid = r_word_valid;
    assign o_byte_cnt   = r_cnt;

    // Shift bytes in; on the final byte the full word is captured directly
    // from the shift register plus the incoming byte, so the word is ready
    // exactly one cycle after its last byte.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shift      <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_word_valid <= 1'b0;
            if (i_clear) begin
                r_cnt <= '0;
            end else if (i_valid) begin
                r_shift <= {r_shift[15:0], i_byte};
                r_cnt   <= r_cnt + 2'd1;
                if (w_last) begin
                    r_word       <= {r_shift, i_byte};
                    r_word_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
// Writer side of the core instruction/data memory. Receives a framed byte
// stream (word count, start address, payload, XOR checksum), writes payload
// words through a single write port and releases the core once the checksum
// matches.
//
// Ports:
//   i_clk1       system clock, rising edge
//   i_rst        synchronous active-high reset
//   i_start      one-cycle pulse, arms a load from IDLE/DONE/ERR
//   i_in_valid   stream byte available
//   i_in_data    stream byte
//   o_in_ready   byte accepted when high together with i_in_valid
//   o_mem_we     one-cycle memory write strobe
//   o_mem_addr   memory word address
//   o_mem_wdata  memory word data
//   o_core_halt  keeps the core halted
//   o_done       load finished with good checksum
//   o_error      load failed (range or checksum)
// ---------------------------------------------------------------------------
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
)
(
    input  logic              i_clk1,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_in_valid,
    input  logic [7:0]        i_in_data,
    output logic              o_in_ready,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_core_halt,
    output logic              o_done,
    output logic              o_error
);

    localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);

    state_t            r_state;
    state_t            w_next;
    logic [23:0]       r_hdr;
    logic [1:0]        r_hdr_cnt;
    logic [7:0]        r_xor;
    logic [15:0]       r_words_left;
    logic [ADDR_W-1:0] r_addr;

    logic              w_in_ready;
    logic              w_xfer;
    logic              w_start_load;
    logic              w_hdr_last;
    logic              w_word_last;
    logic              w_range_bad;
    logic [31:0]       w_hdr_next;
    logic [15:0]       w_n;
    logic [15:0]       w_s;
    logic [31:0]       w_pk_word;
    logic              w_pk_word_valid;
    logic [1:0]        w_pk_cnt;

    assign w_in_ready  = (r_state == HDR) || (r_state == DATA) || (r_state == CSUM);
    assign w_xfer      = i_in_valid && w_in_ready;
    assign w_hdr_next  = {r_hdr, i_in_data};
    assign w_n         = w_hdr_next[31:16];
    assign w_s         = w_hdr_next[15:0];
    assign w_hdr_last  = w_xfer && (r_state == HDR) && (r_hdr_cnt == 2'(HDR_BYTES - 1));
    assign w_word_last = w_xfer && (r_state == DATA) && (w_pk_cnt == 2'(BYTES_PER_WORD - 1));
    // 17-bit sum so a start near the top plus a large count cannot wrap.
    assign w_range_bad = ({1'b0, w_s} + {1'b0, w_n}) > DEPTH;

    prog_loader_byte_packer u_packer (
        .i_clk        (i_clk1),
        .i_rst        (i_rst),
        .i_clear      (w_start_load),
        .i_valid      (w_xfer && (r_state == DATA)),
        .i_byte       (i_in_data),
        .o_word       (w_pk_word),
        .o_word_valid (w_pk_word_valid),
        .o_byte_cnt   (w_pk_cnt)
    );

    // State register.
    always_ff @(posedge i_clk1) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and status outputs. The last word's write lands while the
    // FSM already sits in CSUM, which keeps one byte per cycle throughput.
    always_comb begin
        w_next       = r_state;
        w_start_load = 1'b0;
        o_done       = 1'b0;
        o_error      = 1'b0;
        o_core_halt  = 1'b1;
        case (r_state)
            IDLE, DONE, ERR: begin
                o_done      = (r_state == DONE);
                o_error     = (r_state == ERR);
                o_core_halt = (r_state != DONE);
                if (i_start) begin
                    w_start_load = 1'b1;
                    w_next       = HDR;
                end
            end
            HDR: begin
                if (w_hdr_last) begin
                    if (w_range_bad) begin
                        w_next = ERR;
                    end else if (w_n == 16'd0) begin
                        w_next = CSUM;
                    end else begin
                        w_next = DATA;
                    end
                end
            end
            DATA: begin
                if (w_word_last && (r_words_left == 16'd1)) begin
                    w_next = CSUM;
                end
            end
            CSUM: begin
                if (w_xfer) begin
                    w_next = (i_in_data == r_xor) ? DONE : ERR;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Frame datapath: header capture, running XOR, word counter and the
    // write address, which advances after every issued write.
    always_ff @(posedge i_clk1) begin
        if (i_rst) begin
            r_hdr        <= '0;
            r_hdr_cnt    <= '0;
            r_xor        <= '0;
            r_words_left <= '0;
            r_addr       <= '0;
        end else if (w_start_load) begin
            r_hdr_cnt <= '0;
            r_xor     <= '0;
        end else begin
            if (w_xfer && ((r_state == HDR) || (r_state == DATA))) begin
                r_xor <= r_xor ^ i_in_data;
            end
            if (w_xfer && (r_state == HDR)) begin
                r_hdr     <= w_hdr_next[23:0];
                r_hdr_cnt <= r_hdr_cnt + 2'd1;
                if (w_hdr_last) begin
                    r_words_left <= w_n;
                    r_addr       <= w_s[ADDR_W-1:0];
                end
            end
            if (w_word_last) begin
                r_words_left <= r_words_left - 16'd1;
            end
            if (w_pk_word_valid) begin
                r_addr <= r_addr + 1'b1;
            end
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_mem_we    = w_pk_word_valid;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = DATA_W'(w_pk_word);

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
// Self-checking bench for prog_loader. Frames are built from a word list; the
// expected memory writes (address, data, cycle) are queued as the last byte
// of each word is driven, and a monitor compares every mem_we against the
// queue. Final status is predicted from the frame contents.
// ---------------------------------------------------------------------------
module tb_prog_loader;

    logic        clk1 = 1'b0;
    logic        rst;
    logic        i_start;
    logic        i_in_valid;
    logic [7:0]  i_in_data;
    logic        o_in_ready;
    logic        o_mem_we;
    logic [9:0]  o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        o_core_halt;
    logic        o_done;
    logic        o_error;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t         sbQ[$];
    logic [31:0] pay[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;

    prog_loader #(.ADDR_W(10), .DATA_W(32)) dut (
        .i_clk1      (clk1),
        .i_rst       (rst),
        .i_start     (i_start),
        .i_in_valid  (i_in_valid),
        .i_in_data   (i_in_data),
        .o_in_ready  (o_in_ready),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_core_halt (o_core_halt),
        .o_done      (o_done),
        .o_error     (o_error)
    );

    // Free-running clock and cycle counter used to time the write strobe.
    always #5 clk1 = ~clk1;
    always @(posedge clk1) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk1) begin
        if (o_mem_we === 1'b1) begin
            if (sbQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_write actual=%h@%h required=no write", o_mem_wdata, o_mem_addr);
            end else begin
                wr_t e;
                e = sbQ.pop_front();
                checkOutput("wr_addr", 32'(o_mem_addr), 32'(e.addr));
                checkOutput("wr_data", o_mem_wdata, e.data);
                checkOutput("wr_cycle", cyc, e.cyc);
            end
        end
    end

    // Drives one byte starting at a negedge; returns at the negedge after it
    // was accepted. A write expectation is queued for the following cycle.
    task automatic applyStimulus(input logic [7:0] b, input bit expWrite,
                                 input logic [9:0] eAddr, input logic [31:0] eData);
        int waitCnt = 0;
        i_in_valid = 1'b1;
        i_in_data  = b;
        while (!o_in_ready && waitCnt < 20) begin
            @(negedge clk1);
            waitCnt++;
        end
        if (!o_in_ready) begin
            checkOutput("ready_timeout", 32'(o_in_ready), 32'd1);
        end else begin
            if (expWrite) sbQ.push_back('{addr: eAddr, data: eData, cyc: cyc + 1});
            @(negedge clk1);
        end
        i_in_valid = 1'b0;
    endtask

    // Gap with no valid byte; start is toggled randomly and must be ignored.
    task automatic idleGap(input int stallMax);
        int n;
        n = (stallMax > 0) ? int'($urandom_range(1, stallMax)) : 0;
        i_in_valid = 1'b0;
        repeat (n) begin
            i_start = 1'($urandom % 2);
            @(negedge clk1);
        end
        i_start = 1'b0;
    endtask

    task automatic startPulse();
        i_start = 1'b1;
        @(negedge clk1);
        i_start = 1'b0;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_ready"}, 32'(o_in_ready), 32'd0);
        checkOutput({tag, "_we"},    32'(o_mem_we),   32'd0);
        checkOutput({tag, "_addr"},  32'(o_mem_addr), 32'd0);
        checkOutput({tag, "_wdata"}, o_mem_wdata,     32'd0);
        checkOutput({tag, "_halt"},  32'(o_core_halt), 32'd1);
        checkOutput({tag, "_done"},  32'(o_done),     32'd0);
        checkOutput({tag, "_error"}, 32'(o_error),    32'd0);
    endtask

    // Full frame from pay[]: the model predicts writes from S and N directly,
    // the checksum as the XOR of all bytes sent, and the final status.
    task automatic loadFrame(input int n, input int s, input bit badCsum, input int stallMax);
        logic [7:0]  hdr[4];
        logic [7:0]  x;
        logic [7:0]  byt;
        logic [31:0] word;
        bit          ovf;
        x      = 8'h00;
        hdr[0] = n[15:8];
        hdr[1] = n[7:0];
        hdr[2] = s[15:8];
        hdr[3] = s[7:0];
        ovf    = (s + n) > 1024;
        startPulse();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) idleGap(stallMax);
            applyStimulus(hdr[i], 1'b0, 10'd0, 32'd0);
            x ^= hdr[i];
        end
        if (ovf) begin
            checkOutput("ovf_ready", 32'(o_in_ready), 32'd0);
            checkOutput("ovf_error", 32'(o_error), 32'd1);
            checkOutput("ovf_halt", 32'(o_core_halt), 32'd1);
            checkOutput("ovf_done", 32'(o_done), 32'd0);
            repeat (3) @(negedge clk1);
        end else begin
            for (int w = 0; w < n; w++) begin
                word = pay[w];
                for (int b = 0; b < 4; b++) begin
                    idleGap(stallMax);
                    byt = word[31 - 8 * b -: 8];
                    applyStimulus(byt, b == 3, 10'(s + w), word);
                    x ^= byt;
                end
            end
            idleGap(stallMax);
            applyStimulus(badCsum ? (x ^ 8'h01) : x, 1'b0, 10'd0, 32'd0);
            repeat (2) @(negedge clk1);
            checkOutput("end_done", 32'(o_done), 32'(!badCsum));
            checkOutput("end_error", 32'(o_error), 32'(badCsum));
            checkOutput("end_halt", 32'(o_core_halt), 32'(badCsum));
            checkOutput("end_ready", 32'(o_in_ready), 32'd0);
        end
        checkOutput("writes_left", 32'(sbQ.size()), 32'd0);
        sbQ.delete();
    endtask

    task automatic setNominal();
        pay.delete();
        pay.push_back(32'h280a00c8);
        pay.push_back(32'h28020001);
        pay.push_back(32'hfc000000);
    endtask

    // Hard bound on the whole run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int s;
        rst        = 1'b1;
        i_start    = 1'b0;
        i_in_valid = 1'b0;
        i_in_data  = 8'h00;
        repeat (3) @(negedge clk1);
        checkReset("rst");
        rst = 1'b0;
        @(negedge clk1);

        $display("[TB] nominal load");
        setNominal();
        loadFrame(3, 0, 1'b0, 0);

        $display("[TB] bad checksum");
        loadFrame(3, 0, 1'b1, 0);

        $display("[TB] empty frame");
        loadFrame(0, 16, 1'b0, 0);

        $display("[TB] range overflow");
        loadFrame(2, 1023, 1'b0, 0);

        $display("[TB] stalled stream");
        loadFrame(3, 0, 1'b0, 5);

        $display("[TB] reset mid-DATA");
        startPulse();
        applyStimulus(8'h00, 1'b0, 10'd0, 32'd0);
        applyStimulus(8'h03, 1'b0, 10'd0, 32'd0);
        applyStimulus(8'h00, 1'b0, 10'd0, 32'd0);
        applyStimulus(8'h00, 1'b0, 10'd0, 32'd0);
        applyStimulus(8'h28, 1'b0, 10'd0, 32'd0);
        applyStimulus(8'h0a, 1'b0, 10'd0, 32'd0);
        applyStimulus(8'h00, 1'b0, 10'd0, 32'd0);
        applyStimulus(8'hc8, 1'b1, 10'd0, 32'h280a00c8);
        applyStimulus(8'h28, 1'b0, 10'd0, 32'd0);
        applyStimulus(8'h02, 1'b0, 10'd0, 32'd0);
        rst = 1'b1;
        @(negedge clk1);
        checkReset("midrst");
        rst = 1'b0;
        @(negedge clk1);
        checkReset("postrst");
        checkOutput("midrst_writes_left", 32'(sbQ.size()), 32'd0);
        loadFrame(3, 0, 1'b0, 0);

        $display("[TB] random frames");
        for (int f = 0; f < 10; f++) begin
            n = int'($urandom_range(0, 6));
            if ($urandom % 3 == 0) s = 1024 - n + int'($urandom_range(0, 2));
            else s = int'($urandom_range(0, 1000));
            pay.delete();
            for (int w = 0; w < n; w++) pay.push_back($urandom);
            loadFrame(n, s, 1'($urandom % 4 == 0), int'($urandom_range(0, 5)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
